// File: rtl/harvard_wait_data_memory.sv
// harvard_wait_data_memory: word-organised data RAM for the Harvard CPU data
// port, with byte enables, a programmable base address and a programmable
// access latency reported through a data_waitrequest stall handshake.
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   defined   - out-of-range accesses raise data_error in their completion
//               cycle, read back as zero and never write the array.
//   undefined - data_error is tied low and the word index wraps onto the array.
module harvard_wait_data_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_byteenable,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic        data_error
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          req;
  logic          wait_req;
  logic          complete;
  logic          done;
  logic          range_ok;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          unused_offset;

  logic [31:0]   mem [DEPTH_WORDS];

  assign req    = data_read | data_write;
  assign offset = data_address - BASE_ADDR;
  assign idx    = offset[AW+1:2];

`ifdef MEM_RANGE_CHECK_EN
  // Range is judged on the full word index; the low byte-offset bits are ignored.
  assign range_ok      = ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
  assign data_error    = done & ~range_ok;
  assign unused_offset = ^offset[1:0];
`else
  // Without checking, upper index bits are dropped so addresses alias onto the array.
  assign range_ok      = 1'b1;
  assign data_error    = 1'b0;
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};
`endif

  // Next-state, counter and handshake decode for the latency FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    wait_req   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            wait_req   = 1'b1;
            cnt_next   = LAT_M1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // CPU withdrew the request: abandon it, the next one pays full latency.
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt != 4'd0) begin
          wait_req = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Reset forces the visible handshake to its idle values and blocks completion.
  assign done             = complete & ~reset;
  assign data_waitrequest = wait_req & ~reset;
  assign data_readdata    = (done && data_read && !data_write && range_ok) ? mem[idx] : 32'd0;

  // State register; reset wins over clk_enable, clk_enable low freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (clk_enable) begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Byte-lane write port, committing only at the close of a completion cycle.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; clearing it would defeat RAM inference.
    if (clk_enable && done && data_write && range_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (data_byteenable[i]) begin
          mem[idx][8*i +: 8] <= data_writedata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_harvard_wait_data_memory.sv
// Self-checking bench for harvard_wait_data_memory. Three instances cover
// zero latency, latency 3, and a 16-word window at 0x1000 with latency 1.
// Expected data comes from an associative-array memory model built from the
// address/byte-enable rules; expected latency from the instance parameters.
module tb_harvard_wait_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce     [3];
  logic [31:0] addr   [3];
  logic [3:0]  be     [3];
  logic        wr     [3];
  logic        rd     [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        waitr  [3];
  logic        err    [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  harvard_wait_data_memory #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .clk_enable(ce[0]), .data_address(addr[0]),
    .data_byteenable(be[0]), .data_write(wr[0]), .data_read(rd[0]),
    .data_writedata(wdata[0]), .data_readdata(rdata[0]),
    .data_waitrequest(waitr[0]), .data_error(err[0]));

  harvard_wait_data_memory #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .clk_enable(ce[1]), .data_address(addr[1]),
    .data_byteenable(be[1]), .data_write(wr[1]), .data_read(rd[1]),
    .data_writedata(wdata[1]), .data_readdata(rdata[1]),
    .data_waitrequest(waitr[1]), .data_error(err[1]));

  harvard_wait_data_memory #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(16), .LATENCY(1)) dut_rg (
    .clk(clk), .reset(reset), .clk_enable(ce[2]), .data_address(addr[2]),
    .data_byteenable(be[2]), .data_write(wr[2]), .data_read(rd[2]),
    .data_writedata(wdata[2]), .data_readdata(rdata[2]),
    .data_waitrequest(waitr[2]), .data_error(err[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000 : 32'h0;
  endfunction

  function automatic logic [31:0] depth_of(input int d);
    return (d == 2) ? 32'd16 : 32'd1024;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on instance d, started #1 after a rising edge.
  // freeze = number of wait cycles (after the first) with clk_enable held low.
  task automatic access(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input string tag,
                        input int freeze);
    int          waits;
    logic [31:0] widx;
    logic        inr;
    logic        chk;
    logic        blocked;
    int          key;
    logic [31:0] exp_rd;
    logic [31:0] merged;
`ifdef MEM_RANGE_CHECK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    widx    = (a - base_of(d)) >> 2;
    inr     = (widx < depth_of(d));
    blocked = chk && !inr;
    key     = d * 65536 + int'(widx % depth_of(d));
    exp_rd  = (r && !w && !blocked) ? model[key] : 32'd0;

    addr[d] = a; be[d] = b; wr[d] = w; rd[d] = r; wdata[d] = wd;
    waits = 0;
    @(negedge clk);
    while (waitr[d] === 1'b1 && waits < 40) begin
      waits++;
      @(posedge clk); #1;
      ce[d] = (waits <= freeze) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check({tag, "_lat"}, waits, lat_of(d) + freeze);
    check({tag, "_rdata"}, rdata[d], exp_rd);
    check({tag, "_err"}, err[d], blocked);
    @(posedge clk); #1;
    if (w && !blocked) begin
      merged = model.exists(key) ? model[key] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (b[i]) merged[8*i +: 8] = wd[8*i +: 8];
      model[key] = merged;
    end
    wr[d] = 1'b0; rd[d] = 1'b0; ce[d] = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ce[d] = 1'b1; addr[d] = '0; be[d] = '0; wr[d] = 1'b0; rd[d] = 1'b0; wdata[d] = '0;
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_wait", waitr[d], 1'b0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_err", err[d], 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill words 0..9 on the two full-size instances.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 10; w++)
        access(d, 1'b1, 1'b0, 32'(w * 4), 4'hF, $urandom, "init", 0);

    // Zero latency: full write, read back, partial write, read back.
    access(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, "l0_wr", 0);
    access(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h0, "l0_rd", 0);
    access(0, 1'b1, 1'b0, 32'h10, 4'b0001, 32'h000000FF, "l0_pwr", 0);
    access(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h0, "l0_prd", 0);
    check("l0_partial_value", model[16'd4], 32'hDEADBEFF);
    // Write and read together: treated as a write, no read data.
    access(0, 1'b1, 1'b1, 32'h14, 4'b1100, 32'hCAFE0000, "l0_wrrd", 0);
    access(0, 1'b0, 1'b1, 32'h14, 4'hF, 32'h0, "l0_wrrd_chk", 0);

    // Latency 3, read held, then idle afterwards.
    access(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'h0, "l3_rd", 0);
    @(negedge clk);
    check("l3_idle_wait", waitr[1], 1'b0);
    check("l3_idle_rdata", rdata[1], 32'd0);
    @(posedge clk); #1;

    // Latency 3, write aborted after one wait cycle.
    addr[1] = 32'h24; be[1] = 4'hF; wdata[1] = 32'h0BADF00D; wr[1] = 1'b1; rd[1] = 1'b0;
    @(negedge clk);
    check("abort_wait0", waitr[1], 1'b1);
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    check("abort_drop_wait", waitr[1], 1'b0);
    @(posedge clk); #1;
    access(1, 1'b0, 1'b1, 32'h24, 4'hF, 32'h0, "abort_rd", 0);

    // Latency 3, reset asserted in the completion cycle of a write.
    addr[1] = 32'h20; be[1] = 4'hF; wdata[1] = 32'h12345678; wr[1] = 1'b1; rd[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_wait", waitr[1], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    check("rst_after_wait", waitr[1], 1'b0);
    @(posedge clk); #1;
    access(1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, "rst_rd", 0);

    // Latency 3 with clk_enable low for two wait cycles.
    access(1, 1'b0, 1'b1, 32'h18, 4'hF, 32'h0, "ce_freeze", 2);
    access(1, 1'b1, 1'b0, 32'h1C, 4'b0110, 32'h55AA55AA, "ce_freeze_wr", 2);
    access(1, 1'b0, 1'b1, 32'h1C, 4'hF, 32'h0, "ce_freeze_rd", 0);

    // Randomised traffic on the two full-size instances.
    for (int i = 0; i < 24; i++) begin
      int          d;
      logic        w;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      access(d, w, !w || 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand", 0);
    end

    // Range window 0x1000..0x103F, latency 1.
    access(2, 1'b1, 1'b0, 32'h1000, 4'hF, 32'hA5A50001, "rg_w0", 0);
    access(2, 1'b1, 1'b0, 32'h103C, 4'hF, 32'hA5A5000F, "rg_w15", 0);
    access(2, 1'b0, 1'b1, 32'h1040, 4'hF, 32'h0, "rg_rd_oor", 0);
    access(2, 1'b0, 1'b1, 32'h0FFC, 4'hF, 32'h0, "rg_rd_below", 0);
    access(2, 1'b1, 1'b0, 32'h1040, 4'hF, 32'h0BAD0BAD, "rg_wr_oor", 0);
    access(2, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0, "rg_rd_w0", 0);
    access(2, 1'b0, 1'b1, 32'h103C, 4'hF, 32'h0, "rg_rd_w15", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
